// File: rtl/aes_control_fsm.sv
// Sequencing controller for the byte-serial AES-128 datapath: walks key expansion,
// initial AddRoundKey, the round loop and output drain, and drives the user handshake.
module aes_control_fsm #(
  parameter int NUM_ROUNDS      = 10,
  parameter int BYTES_PER_ROUND = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       encrypt_in,
  input  logic       new_key,
  input  logic [3:0] inner_state_counter,
  output logic       busy,
  output logic       in_ready,
  output logic       out_valid,
  output logic       done,
  output logic       err,
  output logic       rst_synch,
  output logic       en_generator,
  output logic       encrypt,
  output logic       first_round,
  output logic [3:0] round_counter,
  output logic       read_key_in,
  output logic       load_round_key,
  output logic       save_round_key,
  output logic [7:0] addr_round_key_mem,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEXP  = 3'd1,
    S_SYNC  = 3'd2,
    S_LOAD  = 3'd3,
    S_ROUND = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [3:0] LAST_BYTE  = 4'(BYTES_PER_ROUND - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] rc_q, rc_d;
  logic       enc_q, enc_d;
  logic       nk_q, nk_d;
  logic       kexp_pend_q, kexp_pend_d;
  logic       key_loaded_q, key_loaded_d;
  logic       err_q, err_d;
  logic       last_byte;
  logic       gen_keys;
  logic [3:0] rsel;

  assign last_byte = (inner_state_counter == LAST_BYTE);
  assign gen_keys  = enc_q & nk_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rc_q         <= 4'd0;
      enc_q        <= 1'b0;
      nk_q         <= 1'b0;
      kexp_pend_q  <= 1'b0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      enc_q        <= enc_d;
      nk_q         <= nk_d;
      kexp_pend_q  <= kexp_pend_d;
      key_loaded_q <= key_loaded_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    enc_d        = enc_q;
    nk_d         = nk_q;
    kexp_pend_d  = kexp_pend_q;
    key_loaded_d = key_loaded_q;
    err_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!new_key && !key_loaded_q) begin
            err_d = 1'b1;
          end else begin
            enc_d       = encrypt_in;
            nk_d        = new_key;
            kexp_pend_d = !encrypt_in && new_key;
            rc_d        = 4'd0;
            state_d     = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        rc_d        = 4'd0;
        kexp_pend_d = 1'b0;
        state_d     = kexp_pend_q ? S_KEXP : S_LOAD;
      end
      S_KEXP: begin
        if (last_byte) begin
          if (rc_q == LAST_ROUND) begin
            rc_d         = 4'd0;
            key_loaded_d = 1'b1;
            state_d      = S_SYNC;
          end else begin
            rc_d = rc_q + 4'd1;
          end
        end
      end
      S_LOAD: begin
        if (last_byte) begin
          rc_d    = 4'd1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (last_byte) begin
          if (rc_q == LAST_ROUND) begin
            rc_d    = 4'd0;
            state_d = S_DRAIN;
            if (gen_keys) key_loaded_d = 1'b1;
          end else begin
            rc_d = rc_q + 4'd1;
          end
        end
      end
      S_DRAIN: if (last_byte) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake: in_ready means the datapath consumes data_in/key_in this cycle and
  // out_valid means data_out holds a result byte this cycle; neither waits on the user.
  always_comb begin
    busy               = 1'b0;
    in_ready           = 1'b0;
    out_valid          = 1'b0;
    done               = 1'b0;
    err                = err_q;
    rst_synch          = 1'b0;
    en_generator       = 1'b0;
    encrypt            = 1'b0;
    first_round        = 1'b0;
    round_counter      = 4'd0;
    read_key_in        = 1'b0;
    load_round_key     = 1'b0;
    save_round_key     = 1'b0;
    addr_round_key_mem = 8'd0;
    rsel               = enc_q ? rc_q : (LAST_ROUND - rc_q);
    unique case (state_q)
      S_IDLE: ;
      S_SYNC: begin
        busy      = 1'b1;
        rst_synch = 1'b1;
        encrypt   = enc_q;
      end
      S_KEXP: begin
        // Key expansion always runs forward, filling memory in round order.
        busy               = 1'b1;
        encrypt            = 1'b1;
        en_generator       = 1'b1;
        save_round_key     = 1'b1;
        round_counter      = rc_q;
        addr_round_key_mem = {rc_q, inner_state_counter};
        if (rc_q == 4'd0) begin
          read_key_in = 1'b1;
          in_ready    = 1'b1;
        end
      end
      S_LOAD, S_ROUND: begin
        busy               = 1'b1;
        encrypt            = enc_q;
        round_counter      = rc_q;
        addr_round_key_mem = {rsel, inner_state_counter};
        if (state_q == S_LOAD) begin
          first_round = 1'b1;
          in_ready    = 1'b1;
        end
        if (gen_keys) begin
          en_generator   = 1'b1;
          save_round_key = 1'b1;
          read_key_in    = (state_q == S_LOAD);
        end else begin
          load_round_key = 1'b1;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        encrypt   = enc_q;
        out_valid = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_control_fsm.sv
// Directed bench for aes_control_fsm with a free-running model of the datapath
// byte counter that clears on rst_synch.
module tb_aes_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       encrypt_in = 1'b0;
  logic       new_key = 1'b0;
  logic [3:0] inner_state_counter = 4'd0;
  logic       busy, in_ready, out_valid, done, err, rst_synch;
  logic       en_generator, encrypt, first_round;
  logic [3:0] round_counter;
  logic       read_key_in, load_round_key, save_round_key;
  logic [7:0] addr_round_key_mem;
  logic [2:0] dbg_state;
  logic [23:0] all_out;

  int checks = 0;
  int errors = 0;
  int mism_hs, mism_ct, mism_rc, mism_ad;
  string msg_hs, msg_ct, msg_rc, msg_ad;

  aes_control_fsm dut (
    .clk(clk), .rst(rst), .start(start), .encrypt_in(encrypt_in), .new_key(new_key),
    .inner_state_counter(inner_state_counter), .busy(busy), .in_ready(in_ready),
    .out_valid(out_valid), .done(done), .err(err), .rst_synch(rst_synch),
    .en_generator(en_generator), .encrypt(encrypt), .first_round(first_round),
    .round_counter(round_counter), .read_key_in(read_key_in),
    .load_round_key(load_round_key), .save_round_key(save_round_key),
    .addr_round_key_mem(addr_round_key_mem), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) inner_state_counter <= rst_synch ? 4'd0 : inner_state_counter + 4'd1;

  assign all_out = {busy, in_ready, out_valid, done, err, rst_synch, en_generator, encrypt,
                    first_round, round_counter, read_key_in, load_round_key, save_round_key,
                    addr_round_key_mem};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Starts a block at cycle 0 and compares every output against a cycle-indexed model
  // until the first IDLE cycle after done; mismatches are tallied per signal group.
  task automatic run_block(input logic enc, input logic nk, input logic hold);
    int off, p, r, b;
    logic k;
    logic [5:0] e_hs, a_hs, e_ct, a_ct;
    logic [3:0] e_rc;
    logic [7:0] e_ad;
    k = !enc && nk;
    off = k ? 177 : 0;
    mism_hs = 0; mism_ct = 0; mism_rc = 0; mism_ad = 0;
    msg_hs = ""; msg_ct = ""; msg_rc = ""; msg_ad = "";
    start = 1'b1; encrypt_in = enc; new_key = nk;
    for (int c = 1; c <= off + 195; c++) begin
      step();
      if (!hold) start = 1'b0;
      e_hs = '0; e_ct = '0; e_rc = '0; e_ad = '0;
      // e_hs = {busy, out_valid, done, err, rst_synch, in_ready}
      // e_ct = {en_generator, encrypt, first_round, read_key_in, load_round_key, save_round_key}
      if (c <= off + 193) begin
        e_hs[5] = 1'b1;
        e_ct[4] = enc;
      end
      if (c == 1 || (k && c == 178)) e_hs[1] = 1'b1;
      if (k && c >= 2 && c <= 177) begin
        p = c - 2; r = p / 16; b = p % 16;
        e_ct[5] = 1'b1; e_ct[4] = 1'b1; e_ct[0] = 1'b1;
        if (r == 0) begin
          e_ct[2] = 1'b1;
          e_hs[0] = 1'b1;
        end
        e_rc = 4'(r);
        e_ad = 8'(r * 16 + b);
      end
      p = c - off - 2;
      if (p >= 0 && p < 176) begin
        r = p / 16; b = p % 16;
        e_rc = 4'(r);
        e_ad = enc ? 8'(r * 16 + b) : 8'((10 - r) * 16 + b);
        if (r == 0) begin
          e_ct[3] = 1'b1;
          e_hs[0] = 1'b1;
        end
        if (enc && nk) begin
          e_ct[5] = 1'b1; e_ct[0] = 1'b1;
          if (r == 0) e_ct[2] = 1'b1;
        end else begin
          e_ct[1] = 1'b1;
        end
      end
      if (p >= 176 && p < 192) e_hs[4] = 1'b1;
      if (p == 192) e_hs[3] = 1'b1;
      a_hs = {busy, out_valid, done, err, rst_synch, in_ready};
      a_ct = {en_generator, encrypt, first_round, read_key_in, load_round_key, save_round_key};
      if (a_hs !== e_hs) begin
        if (mism_hs == 0) msg_hs = $sformatf("cycle %0d got %b want %b", c, a_hs, e_hs);
        mism_hs++;
      end
      if (a_ct !== e_ct) begin
        if (mism_ct == 0) msg_ct = $sformatf("cycle %0d got %b want %b", c, a_ct, e_ct);
        mism_ct++;
      end
      if (round_counter !== e_rc) begin
        if (mism_rc == 0) msg_rc = $sformatf("cycle %0d got %0d want %0d", c, round_counter, e_rc);
        mism_rc++;
      end
      if (addr_round_key_mem !== e_ad) begin
        if (mism_ad == 0) msg_ad = $sformatf("cycle %0d got %0d want %0d", c, addr_round_key_mem, e_ad);
        mism_ad++;
      end
    end
  endtask

  task automatic check_block(input string name);
    checks++;
    if (mism_hs !== 0) begin errors++; $display("FAIL %s_handshake: %0d bad cycles, first %s", name, mism_hs, msg_hs); end
    checks++;
    if (mism_ct !== 0) begin errors++; $display("FAIL %s_control: %0d bad cycles, first %s", name, mism_ct, msg_ct); end
    checks++;
    if (mism_rc !== 0) begin errors++; $display("FAIL %s_round_counter: %0d bad cycles, first %s", name, mism_rc, msg_rc); end
    checks++;
    if (mism_ad !== 0) begin errors++; $display("FAIL %s_addr: %0d bad cycles, first %s", name, mism_ad, msg_ad); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL %s_end_state: got %0d want 0", name, dbg_state); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (all_out !== 24'd0) begin errors++; $display("FAIL reset_outputs: got %h want 000000", all_out); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b1; start = 1'b1; encrypt_in = 1'b1; new_key = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (all_out !== 24'd0) begin errors++; $display("FAIL rst_beats_start_outputs: got %h want 000000", all_out); end
    step();
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_beats_start_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_reject(input string name);
    start = 1'b1; encrypt_in = 1'b0; new_key = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL %s_err: got %b want 1", name, err); end
    checks++;
    if (all_out !== 24'h080000) begin errors++; $display("FAIL %s_only_err: got %h want 080000", name, all_out); end
    step();
    checks++;
    if (all_out !== 24'd0) begin errors++; $display("FAIL %s_err_one_cycle: got %h want 000000", name, all_out); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL %s_state: got %0d want 0", name, dbg_state); end
  endtask

  task automatic test_encrypt_new_key();
    run_block(1'b1, 1'b1, 1'b0);
    check_block("enc_new_key");
  endtask

  task automatic test_decrypt_stored_key();
    run_block(1'b0, 1'b0, 1'b0);
    check_block("dec_stored_key");
  endtask

  task automatic test_decrypt_new_key();
    do_reset();
    run_block(1'b0, 1'b1, 1'b0);
    check_block("dec_new_key");
  endtask

  task automatic test_reset_mid_block();
    start = 1'b1; encrypt_in = 1'b1; new_key = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 50; c++) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_rst: got %b want 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (all_out !== 24'd0) begin errors++; $display("FAIL mid_rst_outputs: got %h want 000000", all_out); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL mid_rst_state: got %0d want 0", dbg_state); end
    test_reject("mid_rst_reject");
  endtask

  task automatic test_back_to_back();
    run_block(1'b1, 1'b1, 1'b1);
    check_block("held_start");
    step();
    checks++;
    if (rst_synch !== 1'b1) begin errors++; $display("FAIL second_rst_synch: got %b want 1", rst_synch); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL second_busy: got %b want 1", busy); end
    start = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_reject("reject_after_reset");
    test_encrypt_new_key();
    test_decrypt_stored_key();
    test_decrypt_new_key();
    test_reset_mid_block();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_control_fsm.md
Name: aes_control_fsm

Overview:
Sequencing controller for the byte-serial AES-128 datapath. It takes a block request from the user and drives every datapath control input (rst_synch, en_generator, encrypt, first_round, round_counter, read_key_in, load_round_key, save_round_key, addr_round_key_mem). It tracks the datapath's inner_state_counter to find byte and round boundaries. It also provides the user handshake (busy, in_ready, out_valid, done, err) and manages round-key memory validity across blocks.

Parameters:
NUM_ROUNDS, 10, AES rounds per block (AES-128)
BYTES_PER_ROUND, 16, bytes per state; fixed, matches the 4-bit inner_state_counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  block request, sampled only in IDLE
encrypt_in  input  1  1 = encrypt, 0 = decrypt; captured with start
new_key  input  1  1 = key bytes are supplied with this block; captured with start
inner_state_counter  input  4  byte index 0..15 from the datapath
busy  output  1  high from the cycle after accepted start until done
in_ready  output  1  data_in/key_in byte consumed this cycle
out_valid  output  1  data_out byte valid this cycle
done  output  1  one-cycle pulse after the last output byte
err  output  1  one-cycle pulse when a request is rejected
rst_synch  output  1  zeroes the datapath inner_state_counter
en_generator  output  1  key-schedule generator enable
encrypt  output  1  datapath direction
first_round  output  1  initial AddRoundKey phase
round_counter  output  4  current round 0..NUM_ROUNDS
read_key_in  output  1  key schedule takes key_in
load_round_key  output  1  key schedule reads round-key memory
save_round_key  output  1  key schedule writes round-key memory
addr_round_key_mem  output  8  round-key memory byte address, 0..175

Behaviour:
- Reset: synchronous, active-high. All outputs are 0, state is IDLE, and key_loaded is cleared. Reset asserted mid-operation aborts the block with no done pulse.
- States: IDLE, KEXP, SYNC, LOAD, ROUND, DRAIN, FIN.
- IDLE, start=1:
  - Capture encrypt_in and new_key.
  - Reject (err=1 for one cycle, stay in IDLE) if new_key=0 and key_loaded=0.
  - Decrypt with new_key=1 goes to KEXP.
  - Every other accepted request goes to SYNC.
  - start is ignored while busy=1.
- SYNC: one cycle; rst_synch=1. The next cycle sees inner_state_counter=0.
- KEXP (decrypt with new key only):
  - Duration: (NUM_ROUNDS+1)*16 = 176 cycles.
  - Drives encrypt=1, en_generator=1, save_round_key=1.
  - read_key_in=1 and in_ready=1 for round 0 bytes only.
  - round_counter advances when inner_state_counter=15.
  - Then: set key_loaded, go to SYNC, and start the decrypt run.
  - A rst_synch pulse is issued on KEXP entry.
- LOAD: 16 cycles; first_round=1, round_counter=0, in_ready=1.
  - Encrypt with new_key: read_key_in=1, en_generator=1, save_round_key=1.
  - Otherwise: load_round_key=1.
- ROUND: round_counter runs 1..NUM_ROUNDS, 16 cycles each. It increments on the cycle where inner_state_counter=15.
  - Encrypt with new_key: en_generator=1 and save_round_key=1.
  - Otherwise: load_round_key=1.
  - After round NUM_ROUNDS byte 15, go to DRAIN. If new_key and encrypt, set key_loaded.
- DRAIN: 16 cycles; out_valid=1 with byte order 0..15. Then FIN.
- FIN: done=1 for one cycle; busy falls in the same cycle; return to IDLE.
- encrypt output: holds the captured mode from SYNC through DRAIN. It is 1 throughout KEXP.
- Address generation:
  - Encrypt: addr = round_counter*16 + inner_state_counter.
  - Decrypt: addr = (NUM_ROUNDS - round_counter)*16 + inner_state_counter.
  - Addresses are computed in 8 bits; the maximum is 175 and there is no wrap.
- Latency, start to done:
  - Encrypt, or decrypt with stored key: 1 + 16 + 160 + 16 + 1 = 194 cycles.
  - Decrypt with new key: an extra 177 cycles (rst_synch pulse + KEXP).
- Simultaneous start with rst: rst wins.
- start in the FIN cycle is ignored. A new request is accepted from the following IDLE cycle.
- inner_state_counter is trusted. The FSM never alters it except through rst_synch.

Test Plan:
- Reset, then encrypt start with new_key=1:
  - busy rises next cycle; rst_synch=1 for one cycle.
  - in_ready and read_key_in are high for 16 cycles.
  - round_counter steps 1..10.
  - addr_round_key_mem runs 0..175 in order.
  - out_valid is high for 16 cycles; done pulses at cycle 194.
- Decrypt start with new_key=0 after the test above:
  - No KEXP; load_round_key=1 throughout.
  - The first LOAD address is 160. The round-10 address range is 0..15.
  - done pulses at cycle 194.
- Decrypt start with new_key=0 directly after reset -> err pulses for one cycle, busy stays 0, and no control outputs toggle.
- Decrypt start with new_key=1 after reset:
  - KEXP lasts 176 cycles with save_round_key=1 and read_key_in for the first 16 only.
  - The block then runs as in the second test; done pulses at cycle 371.
- rst asserted at cycle 50 of an encrypt -> next cycle all outputs are 0 and state is IDLE; a decrypt start with new_key=0 then gives err.
- start held high during a run and at the FIN cycle -> no second acceptance until IDLE; the second block's rst_synch pulse comes exactly one cycle after the first IDLE cycle with start=1.
